// File: rtl/imem_uart_loader.sv
// imem_uart_loader
//
// Loads a program image from a UART byte stream into instruction memory.
// Frame: LEN_LO, LEN_HI, LEN words of 4 bytes (LSB first), CHK, where CHK is
// the XOR of every byte from LEN_LO through the last data byte. The CPU is
// held in reset while a frame is in progress or after an aborted frame.
//
// Ports:
//   clk          in   system clock
//   rstn         in   asynchronous active-low reset
//   load_en      in   load-mode level; a rising edge starts a frame
//   rx_valid     in   one-cycle strobe qualifying rx_data
//   rx_data      in   received byte
//   imem_we      out  one-cycle instruction-memory write strobe
//   imem_addr    out  word write address
//   imem_wdata   out  assembled instruction word
//   cpu_hold     out  holds the CPU in reset while 1
//   done         out  sticky: frame loaded with matching checksum
//   error        out  sticky: frame aborted (length, checksum, timeout, load_en drop)
//   words_loaded out  words written in the current or last frame
//   dbg_state    out  current FSM state, for observation only
//
// Handshake: rx_valid has no back-pressure. A byte is consumed on the rising
// clk edge where rx_valid is 1; rx_valid may be high on consecutive cycles.
// imem_we is a single-cycle strobe with imem_addr/imem_wdata valid alongside.

module imem_uart_loader #(
    parameter int ADDR_WIDTH     = 14,
    parameter int BASE_ADDR      = 0,
    parameter int TIMEOUT_CYCLES = 10_000_000
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  load_en,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  error,
    output logic [15:0]           words_loaded,
    output logic [2:0]            dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_LO = 3'd1,
        S_LEN_HI = 3'd2,
        S_DATA   = 3'd3,
        S_CHECK  = 3'd4,
        S_DONE   = 3'd5,
        S_ERROR  = 3'd6
    } state_t;

    // Largest legal LEN is the full memory depth; 33 bits covers ADDR_WIDTH up to 32.
    localparam logic [32:0] DEPTH    = 33'(1) << ADDR_WIDTH;
    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

    state_t                state_q, state_d;
    logic                  load_en_q;
    logic [15:0]           len_q, len_d;
    logic [23:0]           wbuf_q, wbuf_d;     // first three bytes of the current word
    logic [1:0]            idx_q, idx_d;
    logic [7:0]            chk_q, chk_d;
    logic [15:0]           wl_q, wl_d;
    logic [31:0]           tmo_q, tmo_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  hold_q, hold_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    logic                  start;
    logic                  fail;
    logic [15:0]           new_len;
    logic [15:0]           wl_inc;

    assign start   = load_en & ~load_en_q;
    assign new_len = {rx_data, len_q[7:0]};
    assign wl_inc  = wl_q + 16'd1;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        wbuf_d  = wbuf_q;
        idx_d   = idx_q;
        chk_d   = chk_q;
        wl_d    = wl_q;
        tmo_d   = tmo_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        hold_d  = hold_q;
        done_d  = done_q;
        err_d   = err_q;
        fail    = 1'b0;

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                // rx_valid is ignored here; only a fresh load_en edge restarts.
                if (start) begin
                    state_d = S_LEN_LO;
                    hold_d  = 1'b1;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    wl_d    = '0;
                    chk_d   = '0;
                    idx_d   = '0;
                    tmo_d   = '0;
                    len_d   = '0;
                    wbuf_d  = '0;
                end
            end

            S_LEN_LO, S_LEN_HI, S_DATA, S_CHECK: begin
                if (!load_en) begin
                    fail = 1'b1;
                end else if (rx_valid) begin
                    tmo_d = '0;
                    chk_d = chk_q ^ rx_data;
                    case (state_q)
                        S_LEN_LO: begin
                            len_d[7:0] = rx_data;
                            state_d    = S_LEN_HI;
                        end
                        S_LEN_HI: begin
                            len_d = new_len;
                            if ({17'd0, new_len} > DEPTH) begin
                                fail = 1'b1;
                            end else if (new_len == 16'd0) begin
                                state_d = S_CHECK;
                            end else begin
                                state_d = S_DATA;
                            end
                        end
                        S_DATA: begin
                            case (idx_q)
                                2'd0: wbuf_d[7:0]   = rx_data;
                                2'd1: wbuf_d[15:8]  = rx_data;
                                2'd2: wbuf_d[23:16] = rx_data;
                                default: begin
                                    // Fourth byte completes the word; address uses the
                                    // pre-increment count.
                                    we_d    = 1'b1;
                                    addr_d  = ADDR_WIDTH'(32'(BASE_ADDR) + 32'(wl_q));
                                    wdata_d = {rx_data, wbuf_q};
                                    wl_d    = wl_inc;
                                    if (wl_inc == len_q) begin
                                        state_d = S_CHECK;
                                    end
                                end
                            endcase
                            idx_d = idx_q + 2'd1;
                        end
                        default: begin
                            // S_CHECK: the received byte is CHK, not part of the sum.
                            chk_d = chk_q;
                            if (rx_data == chk_q) begin
                                state_d = S_DONE;
                                done_d  = 1'b1;
                                hold_d  = 1'b0;
                            end else begin
                                fail = 1'b1;
                            end
                        end
                    endcase
                end else if (tmo_q == TMO_LAST) begin
                    fail = 1'b1;
                end else begin
                    tmo_d = tmo_q + 32'd1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // cpu_hold is left at 1 on failure so the CPU never runs a partial image.
        if (fail) begin
            state_d = S_ERROR;
            err_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            load_en_q <= 1'b0;
            len_q     <= '0;
            wbuf_q    <= '0;
            idx_q     <= '0;
            chk_q     <= '0;
            wl_q      <= '0;
            tmo_q     <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            hold_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            load_en_q <= load_en;
            len_q     <= len_d;
            wbuf_q    <= wbuf_d;
            idx_q     <= idx_d;
            chk_q     <= chk_d;
            wl_q      <= wl_d;
            tmo_q     <= tmo_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            hold_q    <= hold_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign imem_we      = we_q;
    assign imem_addr    = addr_q;
    assign imem_wdata   = wdata_q;
    assign cpu_hold     = hold_q;
    assign done         = done_q;
    assign error        = err_q;
    assign words_loaded = wl_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_imem_uart_loader.sv
// Testbench for imem_uart_loader: directed frames from the test plan plus
// randomized frames, all checked every cycle against a byte-count based
// frame model, with literal expectations for the directed cases.

module tb_imem_uart_loader;

    localparam int AW   = 14;
    localparam int BASE = 16;
    localparam int TO   = 100;

    logic          clk;
    logic          rstn;
    logic          load_en;
    logic          rx_valid;
    logic [7:0]    rx_data;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          cpu_hold;
    logic          done;
    logic          error;
    logic [15:0]   words_loaded;
    logic [2:0]    dbg_state;

    imem_uart_loader #(
        .ADDR_WIDTH    (AW),
        .BASE_ADDR     (BASE),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .load_en     (load_en),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .imem_we     (imem_we),
        .imem_addr   (imem_addr),
        .imem_wdata  (imem_wdata),
        .cpu_hold    (cpu_hold),
        .done        (done),
        .error       (error),
        .words_loaded(words_loaded),
        .dbg_state   (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Tracks the frame as a list of received bytes; everything else is
    // derived from the byte count and the LEN field.
    logic [7:0]       m_bytes[$];
    bit               m_active  = 0;
    bit               m_done    = 0;
    bit               m_err     = 0;
    bit               m_hold    = 0;
    bit               m_we      = 0;
    bit               m_prev_en = 0;
    int               m_wl      = 0;
    int               m_idle    = 0;
    logic [AW+31:0]   exp_q[$];

    task automatic m_fail();
        m_err    = 1;
        m_active = 0;
    endtask

    task automatic m_take_byte();
        int          n;
        int          len;
        int          d;
        logic [7:0]  x;
        logic [31:0] word;
        logic [31:0] a;
        n   = m_bytes.size();
        len = (n >= 2) ? (int'(m_bytes[0]) | (int'(m_bytes[1]) << 8)) : 0;
        if (n == 2) begin
            if (len > (1 << AW)) m_fail();
        end else if (n >= 3) begin
            d = n - 2;
            if (d <= 4 * len) begin
                if (d % 4 == 0) begin
                    m_wl = d / 4;
                    word = {m_bytes[n-1], m_bytes[n-2], m_bytes[n-3], m_bytes[n-4]};
                    a    = 32'((BASE + m_wl - 1) % (1 << AW));
                    m_we = 1;
                    exp_q.push_back({a[AW-1:0], word});
                end
            end else begin
                x = 8'h00;
                for (int i = 0; i < n - 1; i++) x ^= m_bytes[i];
                if (x == m_bytes[n-1]) begin
                    m_done   = 1;
                    m_hold   = 0;
                    m_active = 0;
                end else begin
                    m_fail();
                end
            end
        end
    endtask

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_active  = 0;
            m_done    = 0;
            m_err     = 0;
            m_hold    = 0;
            m_we      = 0;
            m_prev_en = 0;
            m_wl      = 0;
            m_idle    = 0;
            m_bytes.delete();
            exp_q.delete();
        end else begin
            m_we = 0;
            if (!m_active) begin
                if (load_en && !m_prev_en) begin
                    m_active = 1;
                    m_bytes.delete();
                    m_done   = 0;
                    m_err    = 0;
                    m_hold   = 1;
                    m_wl     = 0;
                    m_idle   = 0;
                end
            end else if (!load_en) begin
                m_fail();
            end else if (rx_valid) begin
                m_idle = 0;
                m_bytes.push_back(rx_data);
                m_take_byte();
            end else begin
                m_idle++;
                if (m_idle == TO) m_fail();
            end
            m_prev_en = load_en;
        end
    end

    // ---------------- scoreboard / compare ----------------
    int            wr_count = 0;
    logic [AW-1:0] wr_addr_log[$];
    logic [31:0]   wr_data_log[$];

    always @(negedge clk) begin
        logic [AW+31:0] e;
        check("imem_we", imem_we, m_we);
        check("cpu_hold", cpu_hold, m_hold);
        check("done", done, m_done);
        check("error", error, m_err);
        check("words_loaded", words_loaded, m_wl[15:0]);
        if (m_we && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (imem_we) begin
                check("wr_addr", imem_addr, e[AW+31:32]);
                check("wr_data", imem_wdata, e[31:0]);
            end
        end
        if (imem_we) begin
            wr_count++;
            wr_addr_log.push_back(imem_addr);
            wr_data_log.push_back(imem_wdata);
        end
    end

    // ---------------- drivers ----------------
    logic [7:0] tx_q[$];

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_log();
        wr_count = 0;
        wr_addr_log.delete();
        wr_data_log.delete();
    endtask

    task automatic start_frame();
        load_en = 1'b0;
        @(negedge clk);
        load_en = 1'b1;
        @(negedge clk);
        clear_log();
    endtask

    task automatic send_tx(input int gap_max);
        for (int i = 0; i < tx_q.size(); i++) begin
            rx_valid = 1'b1;
            rx_data  = tx_q[i];
            @(negedge clk);
            rx_valid = 1'b0;
            rx_data  = 8'($urandom);
            if (gap_max > 0) repeat ($urandom_range(gap_max, 0)) @(negedge clk);
        end
    endtask

    task automatic make_frame(input int len, input bit bad);
        logic [31:0] w;
        logic [7:0]  c;
        tx_q.delete();
        tx_q.push_back(8'(len));
        tx_q.push_back(8'(len >> 8));
        for (int i = 0; i < len; i++) begin
            w = $urandom;
            for (int k = 0; k < 4; k++) tx_q.push_back(w[8*k +: 8]);
        end
        c = 8'h00;
        foreach (tx_q[i]) c ^= tx_q[i];
        if (bad) c ^= 8'($urandom_range(255, 1));
        tx_q.push_back(c);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int cnt;
        int len;
        bit bad;
        bit abort;

        rstn     = 1'b0;
        load_en  = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        tick(3);
        check("rst_we", imem_we, 1'b0);
        check("rst_hold", cpu_hold, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_error", error, 1'b0);
        check("rst_wl", words_loaded, 16'd0);
        rstn = 1'b1;
        tick(2);

        // Single word
        start_frame();
        tx_q = '{8'h01, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'hC2};
        send_tx(2);
        tick(2);
        check("sw_done", done, 1'b1);
        check("sw_hold", cpu_hold, 1'b0);
        check("sw_wl", words_loaded, 16'd1);
        check("sw_wr_count", wr_count, 1);
        if (wr_count == 1) begin
            check("sw_addr", wr_addr_log[0], 14'h0010);
            check("sw_data", wr_data_log[0], 32'h00500093);
        end

        // Bad checksum, then a good frame
        start_frame();
        tx_q = '{8'h01, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'hC3};
        send_tx(0);
        tick(2);
        check("bad_error", error, 1'b1);
        check("bad_done", done, 1'b0);
        check("bad_hold", cpu_hold, 1'b1);
        check("bad_wr_count", wr_count, 1);
        start_frame();
        tx_q = '{8'h01, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'hC2};
        send_tx(0);
        tick(2);
        check("retry_done", done, 1'b1);
        check("retry_error", error, 1'b0);

        // Empty frame
        start_frame();
        tx_q = '{8'h00, 8'h00, 8'h00};
        send_tx(1);
        tick(2);
        check("empty_done", done, 1'b1);
        check("empty_wr_count", wr_count, 0);

        // Oversize: error right after LEN_HI
        start_frame();
        tx_q = '{8'h01, 8'h40};
        send_tx(0);
        check("over_error", error, 1'b1);
        check("over_hold", cpu_hold, 1'b1);

        // Exactly full depth is accepted; then abort by dropping load_en
        start_frame();
        tx_q = '{8'h00, 8'h40, 8'h11, 8'h22, 8'h33};
        send_tx(0);
        check("full_len_error", error, 1'b0);
        load_en = 1'b0;
        tick(1);
        check("abort_error", error, 1'b1);
        check("abort_hold", cpu_hold, 1'b1);

        // Back-to-back stream, LEN=3
        start_frame();
        make_frame(3, 1'b0);
        send_tx(0);
        tick(2);
        check("b2b_done", done, 1'b1);
        check("b2b_wr_count", wr_count, 3);
        if (wr_count == 3) begin
            check("b2b_addr0", wr_addr_log[0], 14'h0010);
            check("b2b_addr1", wr_addr_log[1], 14'h0011);
            check("b2b_addr2", wr_addr_log[2], 14'h0012);
            check("b2b_data1", wr_data_log[1], {tx_q[9], tx_q[8], tx_q[7], tx_q[6]});
        end

        // Timeout after two data bytes
        start_frame();
        tx_q = '{8'h02, 8'h00, 8'hAA, 8'hBB};
        send_tx(0);
        cnt = 0;
        while (cnt < 3 * TO) begin
            @(posedge clk);
            #1;
            cnt++;
            if (error) break;
        end
        check("timeout_cycles", cnt, TO);
        check("timeout_wr_count", wr_count, 0);
        tick(1);

        // Reset mid-DATA, then a full frame
        start_frame();
        make_frame(2, 1'b0);
        tx_q = tx_q[0:5];
        send_tx(0);
        #2 rstn = 1'b0;
        #1;
        check("arst_we", imem_we, 1'b0);
        check("arst_hold", cpu_hold, 1'b0);
        check("arst_done", done, 1'b0);
        check("arst_error", error, 1'b0);
        check("arst_wl", words_loaded, 16'd0);
        load_en = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        tick(2);
        start_frame();
        make_frame(3, 1'b0);
        send_tx(2);
        tick(2);
        check("post_rst_done", done, 1'b1);
        check("post_rst_wl", words_loaded, 16'd3);

        // Randomized frames
        for (int it = 0; it < 30; it++) begin
            len   = $urandom_range(5, 0);
            bad   = ($urandom_range(4, 0) == 0);
            abort = ($urandom_range(6, 0) == 0);
            start_frame();
            make_frame(len, bad);
            if (abort) begin
                cnt = $urandom_range(tx_q.size() - 1, 0);
                while (tx_q.size() > cnt) void'(tx_q.pop_back());
            end
            send_tx($urandom_range(3, 0));
            if (abort) load_en = 1'b0;
            tick(3);
            if (!abort) begin
                check("rnd_done", done, !bad);
                check("rnd_wr_count", wr_count, len);
            end else begin
                check("rnd_abort_error", error, 1'b1);
            end
        end

        tick(2);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        n_errors++;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/imem_uart_loader.md
# imem_uart_loader

Loads a program image from a UART byte stream into instruction memory, writing the 32-bit instruction words that fetch and decode later read. It sits between the UART receiver (byte/valid stream) and the write port of instruction memory. It holds the CPU in reset while loading and reports completion or error to the board-level control logic.

## Interface

- `ADDR_WIDTH`, default 14: instruction-memory word-address width. Depth is 2^ADDR_WIDTH words.
- `BASE_ADDR`, default 0: word address of the first loaded instruction.
- `TIMEOUT_CYCLES`, default 10_000_000: maximum idle gap between bytes while a frame is in progress.

Ports:

- `clk` in 1: system clock. This is the block's only clock.
- `rstn` in 1: reset. Asynchronous, active-low.
- `load_en` in 1: load-mode switch, level. A rising edge starts a frame.
- `rx_valid` in 1: single-cycle pulse marking one received byte. Pulses may arrive back-to-back.
- `rx_data` in 8: received byte, valid when `rx_valid` is 1.
- `imem_we` out 1: instruction-memory write strobe, one cycle per word.
- `imem_addr` out ADDR_WIDTH: word write address.
- `imem_wdata` out 32: assembled instruction word.
- `cpu_hold` out 1: holds the CPU in reset while 1.
- `done` out 1: frame loaded and checksum correct. Sticky.
- `error` out 1: frame aborted. Sticky.
- `words_loaded` out 16: number of words written in the current or last frame.

## Operation

- Frame format: LEN_LO, LEN_HI, then LEN words of 4 bytes each, least-significant byte first, then CHK.
  - CHK is the XOR of every byte from LEN_LO through the last data byte.
- States are IDLE, LEN_LO, LEN_HI, DATA, CHECK, DONE and ERROR.
- `load_en` is registered once; the start event is the registered-low to current-high transition.
- **IDLE:** `rx_valid` is ignored. A start event moves to LEN_LO, sets `cpu_hold`=1, clears `done`/`error`/`words_loaded`/checksum/byte index, and resets the timeout counter.
- **LEN_LO:** the byte goes to len[7:0].
- **LEN_HI:** the byte goes to len[15:8]. The next state is decided from the new len value:
  - len > 2^ADDR_WIDTH: ERROR.
  - len == 0: CHECK.
  - otherwise: DATA.
- **DATA:** byte k (k = 0..3) goes to wdata[8k+7:8k].
  - On the 4th byte, `imem_we` pulses for one cycle, `words_loaded` increments, and the byte index wraps to 0.
  - Write address is `imem_addr` = BASE_ADDR + words_loaded (value before the increment), truncated to ADDR_WIDTH.
  - When `words_loaded` reaches len, the state moves to CHECK.
- **CHECK:** the received byte is compared with the running checksum. Equal moves to DONE; otherwise ERROR.
- **DONE:** `done`=1 and `cpu_hold`=0. The state holds until the next start event.
- **ERROR:** `error`=1 and `cpu_hold` stays 1. The state holds until the next start event, which restarts the frame.
- **Timeout:**
  - Applies in LEN_LO, LEN_HI, DATA and CHECK.
  - The counter clears on every `rx_valid`.
  - When TIMEOUT_CYCLES cycles pass with no byte, the state moves to ERROR.
- **`load_en` low** during LEN_LO..CHECK moves to ERROR. Start events are not possible while busy, since `load_en` is already high.
- **Async reset:**
  - Forces IDLE.
  - Clears all outputs to 0, including `cpu_hold`=0 and `imem_we`=0.
  - Clears all internal registers.
  - Applies mid-frame as well; partial memory contents are left as written.

## Timing

- Start event to LEN_LO: 1 cycle after the rising edge of `load_en` is sampled; `cpu_hold` rises on the same edge.
- Each byte is consumed in the cycle its `rx_valid` is high; the state and checksum update on that edge.
- `imem_we`/`imem_addr`/`imem_wdata` are registered. They are valid the cycle after the 4th byte's `rx_valid` and high for exactly one cycle.
- Back-to-back `rx_valid` cannot cause a dropped write, because at most one write is generated per 4 bytes.
- `done`, `error` and `cpu_hold` are registered. They update one cycle after the deciding CHK byte, timeout or abort.
- The timeout fires exactly TIMEOUT_CYCLES cycles after the last `rx_valid` (or after the start event if no byte has arrived).

## Test plan

- **Single word:** bytes 01 00 93 00 50 00 C2 → one `imem_we` with addr 0, data 0x00500093; `words_loaded`=1; `done`=1; `cpu_hold`=0.
- **Bad checksum:** same bytes with CHK=C3 → one write occurs; `error`=1, `done`=0, `cpu_hold` stays 1. The next start with a correct frame gives `done`=1.
- **Empty and oversize frames:**
  - Bytes 00 00 00 → `done`=1 with no writes.
  - With ADDR_WIDTH=14, LEN=0x4001 → `error`=1 right after LEN_HI.
- **Back-to-back stream:** `rx_valid` every cycle, LEN=3, BASE_ADDR=0x10 → writes at 0x10, 0x11, 0x12, each 1 cycle wide, with correct little-endian words; `done`=1.
- **Timeout:** with TIMEOUT_CYCLES=100, stop after 2 data bytes → `error` rises 100 cycles after the last byte; no write occurs.
- **Abort and reset:**
  - Drop `load_en` mid-DATA → `error`=1.
  - Assert `rstn`=0 mid-DATA → all outputs 0 immediately (asynchronously); a following full frame loads correctly.
